// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the 8-bit generator/checker pair: word width,
// checker state encoding and the next-word / bit-count helpers.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    typedef enum logic [1:0] {
        SEARCH0 = 2'd0,
        SEARCH1 = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } lfsr_chk_state_t;

    // w(n+1) = {w(n)[6:0], w(n-1)[7] ^ w(n-1)[6]}
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] prev,
                                                    input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], prev[LFSR_W-1] ^ prev[LFSR_W-2]};
    endfunction

    function automatic logic [3:0] popcount8(input logic [LFSR_W-1:0] w);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < LFSR_W; i++) n += 4'(w[i]);
        return n;
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream/status bundle between an LFSR word source (master) and the checker (slave).
interface lfsr_checker_if #(parameter int ERR_W = 16);
    import lfsr_pkg::*;

    logic              in_valid;
    logic [LFSR_W-1:0] in_bits;
    logic              clear_errors;
    logic              locked;
    logic              err_strobe;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output in_valid, in_bits, clear_errors,
        input  locked, err_strobe, err_count
    );

    modport slave (
        input  in_valid, in_bits, clear_errors,
        output locked, err_strobe, err_count
    );

endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit LFSR stream: search, verify, lock, count errors.
// Define LFSR_CHECKER_BITERR_EN to count mismatched bits instead of mismatched words.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3,
    parameter int ERR_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_checker_if.slave  bus
);

    localparam int MRW = $clog2(LOCK_COUNT + 1);
    localparam int XRW = $clog2(MISS_LIMIT + 1);
    localparam int SW  = ERR_W + 4;
    localparam logic [SW-1:0] MAXV = {4'b0, {ERR_W{1'b1}}};

    lfsr_chk_state_t   state_q;
    logic [LFSR_W-1:0] prev_q, cur_q;
    logic [MRW-1:0]    match_run_q;
    logic [XRW-1:0]    miss_run_q;
    logic              locked_q, err_strobe_q;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic [LFSR_W-1:0] pred;
    logic              hit, err_now, zero_pair;
    logic [3:0]        inc;
    logic [SW-1:0]     base, sum;

    always_comb begin
        pred      = lfsr_next(prev_q, cur_q);
        hit       = (bus.in_bits == pred);
        zero_pair = (cur_q == '0) && (bus.in_bits == '0);
        err_now   = bus.in_valid && (state_q == LOCKED) && !hit;
`ifdef LFSR_CHECKER_BITERR_EN
        inc = popcount8(bus.in_bits ^ pred);
`else
        inc = 4'd1;
`endif
        // clear and a same-cycle error combine: the new error survives the clear
        base = bus.clear_errors ? '0 : SW'(err_cnt_q);
        sum  = base + SW'(inc);
        if (err_now) err_cnt_d = (sum > MAXV) ? '1 : sum[ERR_W-1:0];
        else         err_cnt_d = base[ERR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEARCH0;
            prev_q       <= '0;
            cur_q        <= '0;
            match_run_q  <= '0;
            miss_run_q   <= '0;
            locked_q     <= 1'b0;
            err_strobe_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            err_strobe_q <= err_now;
            if (bus.in_valid) begin
                unique case (state_q)
                    SEARCH0: begin
                        cur_q   <= bus.in_bits;
                        state_q <= SEARCH1;
                    end
                    SEARCH1: begin
                        prev_q      <= cur_q;
                        cur_q       <= bus.in_bits;
                        match_run_q <= '0;
                        // an all-zero pair predicts zeros forever, so keep hunting
                        if (!zero_pair) state_q <= VERIFY;
                    end
                    VERIFY: begin
                        prev_q <= cur_q;
                        cur_q  <= bus.in_bits;
                        if (hit) begin
                            if (int'(match_run_q) + 1 >= LOCK_COUNT) begin
                                state_q     <= LOCKED;
                                locked_q    <= 1'b1;
                                miss_run_q  <= '0;
                                match_run_q <= '0;
                            end else begin
                                match_run_q <= match_run_q + 1'b1;
                            end
                        end else begin
                            match_run_q <= '0;
                            if (zero_pair) state_q <= SEARCH1;
                        end
                    end
                    LOCKED: begin
                        // flywheel on the prediction so a corrupt word never enters history
                        prev_q <= cur_q;
                        cur_q  <= pred;
                        if (hit) begin
                            miss_run_q <= '0;
                        end else if (int'(miss_run_q) + 1 >= MISS_LIMIT) begin
                            state_q    <= SEARCH0;
                            locked_q   <= 1'b0;
                            miss_run_q <= '0;
                        end else begin
                            miss_run_q <= miss_run_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_strobe = err_strobe_q;
    assign bus.err_count  = err_cnt_q;

endmodule
